sc_filter_phase_ctrl: RTL and testbench
=======================================

// Module: sc_filter_phase_ctrl
// PURPOSE
//  Digital sequencer for the switched-capacitor filter core (filter_p_m_fin). Generates the
//  non-overlapping two-phase clocks phi1/phi2 and their complements, samples the comparator
//  output once per frame, and reports polarity and threshold-crossing events to the SoC.
//  Sits between the user clock domain and the filter's phase/compout pins.
// PARAMETERS
//  DIV_W      8   width of half_period_i; phase high time in wb_clk_i cycles
//  NOV_CYC    2   non-overlap dead time in cycles between phases (legal range >=1)
//  EVT_CNT_W  16  width of the saturating event counter
// PORTS
//  wb_clk_i       in   1          single clock
//  wb_rst_i       in   1          reset, asynchronous, active-high
//  en_i           in   1          run request; level-sensitive
//  half_period_i  in   DIV_W      phi high time H in cycles; value 0 is treated as 1
//  clr_i          in   1          one-cycle pulse; clears event_cnt_o
//  compout_i      in   1          comparator output from filter; asynchronous to wb_clk_i
//  phi1_o         out  1          phase 1 to filter
//  phi2_o         out  1          phase 2 to filter
//  phi1b_o        out  1          complement of phi1_o
//  phi2b_o        out  1          complement of phi2_o
//  pol_o          out  1          last sampled comparator polarity
//  event_o        out  1          one-cycle pulse; sampled polarity changed
//  polxevent_o    out  1          one-cycle pulse; event_o and new polarity == 1
//  event_cnt_o    out  EVT_CNT_W  saturating count of event_o pulses
//  busy_o         out  1          1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: phi1_o=0, phi2_o=0, phi1b_o=1, phi2b_o=1, pol_o=0, event_o=0,
//  polxevent_o=0, event_cnt_o=0, busy_o=0, FSM=IDLE, primed=0.
//  Reset asserted at any time forces these values immediately, without waiting for a clock edge.
//  All outputs are driven from flops. phiNb_o has its own flop, loaded with the complement
//  of the next phiN value, so phiNb_o == ~phiN_o on every cycle.
//  FSM states: IDLE -> PH1 -> NOV1 -> PH2 -> NOV2 -> (PH1 | IDLE).
//   IDLE: all phases low; primed cleared. en_i=1 -> PH1 next cycle.
//   PH1: phi1_o=1 for Heff=max(half_period_i,1) cycles. H is latched on entry; changes to
//        half_period_i mid-phase are ignored.
//   NOV1: phi1_o=phi2_o=0 for NOV_CYC cycles.
//   PH2: phi2_o=1 for Heff cycles. H is re-latched on entry.
//   NOV2: both phases low for NOV_CYC cycles. On its last cycle, exit to PH1 if en_i=1,
//        otherwise exit to IDLE.
//  en_i is evaluated only at IDLE and at the last cycle of NOV2, so a frame is never truncated.
//  Frame length = 2*Heff + 2*NOV_CYC cycles. phi1_o and phi2_o are never high together.
//  compout_i passes through a 2-flop synchronizer (csync).
//  Sampling: on the last cycle of NOV2, csync is captured. pol_o updates on the next edge.
//  Event generation:
//   - event_o pulses on that same edge if primed=1 and the captured value != pol_o.
//   - primed is set after the first capture, so the first frame after IDLE never produces an event.
//   - polxevent_o = event_o & new pol_o, with the same timing.
//  event_cnt_o:
//   - increments on each event_o pulse and saturates at all-ones.
//   - clr_i alone clears it to 0.
//   - clr_i in the same cycle as an event_o pulse gives count = 1.
//   - The counter is not cleared by IDLE.
//  busy_o = (state != IDLE), registered with the state.
// TESTING
//  1 H=3, NOV_CYC=2, en_i held 1: phi1_o high for 3 cycles, low 2, phi2_o high 3, low 2;
//    frame = 10 cycles; phi1_o&phi2_o==0 and phiNb_o==~phiN_o on every cycle.
//  2 half_period_i=0: each phase high for exactly 1 cycle; frame = 6 cycles with NOV_CYC=2.
//  3 compout_i held 0,1,1,0,1 across frames 1..5 -> no event in frame 1; event_o in frames
//    2, 4 and 5; polxevent_o in frames 2 and 5; event_cnt_o=3.
//  4 en_i dropped in the 2nd cycle of PH1 -> PH1, NOV1, PH2 and NOV2 complete at full length,
//    then IDLE; busy_o falls; phi1_o=phi2_o=0 and phi1b_o=phi2b_o=1 afterwards.
//  5 wb_rst_i pulsed mid-PH2, between clock edges -> phi2_o=0, phi2b_o=1 and event_cnt_o=0
//    immediately; after release with en_i=1, PH1 starts and the first sample yields no event.
//  6 EVT_CNT_W=2: 4 events -> event_cnt_o stays at 3; clr_i coincident with an event -> 1.

Source files
------------

// File: rtl/sc_filter_phase_ctrl.sv
// Two-phase non-overlapping clock sequencer for the switched-capacitor filter.
// Samples the comparator once per frame and reports polarity changes.
module sc_filter_phase_ctrl #(
    parameter int DIV_W     = 8,
    parameter int NOV_CYC   = 2,
    parameter int EVT_CNT_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 en_i,
    input  logic [DIV_W-1:0]     half_period_i,
    input  logic                 clr_i,
    input  logic                 compout_i,
    output logic                 phi1_o,
    output logic                 phi2_o,
    output logic                 phi1b_o,
    output logic                 phi2b_o,
    output logic                 pol_o,
    output logic                 event_o,
    output logic                 polxevent_o,
    output logic [EVT_CNT_W-1:0] event_cnt_o,
    output logic                 busy_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PH1  = 3'd1;
    localparam logic [2:0] S_NOV1 = 3'd2;
    localparam logic [2:0] S_PH2  = 3'd3;
    localparam logic [2:0] S_NOV2 = 3'd4;

    localparam int NOV_W = $clog2(NOV_CYC + 1);
    localparam int CNT_W = (DIV_W > NOV_W) ? DIV_W : NOV_W;
    localparam logic [CNT_W-1:0] NOV_LAST = CNT_W'(NOV_CYC - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] heff;
    logic [CNT_W-1:0] h_last;
    logic             csync_meta, csync;
    logic             primed;
    logic             sample;
    logic             evt_nxt;

    // A programmed half period of 0 behaves as 1; the down-counter holds H-1 on phase entry.
    assign heff    = (half_period_i == '0) ? DIV_W'(1) : half_period_i;
    assign h_last  = CNT_W'(heff) - CNT_W'(1);
    assign sample  = (state == S_NOV2) && (cnt == '0);
    assign evt_nxt = sample && primed && (csync != pol_o);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (en_i) begin
                    state_nxt = S_PH1;
                    cnt_nxt   = h_last;
                end
            end
            S_PH1: begin
                if (cnt == '0) begin
                    state_nxt = S_NOV1;
                    cnt_nxt   = NOV_LAST;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_NOV1: begin
                if (cnt == '0) begin
                    state_nxt = S_PH2;
                    cnt_nxt   = h_last;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_PH2: begin
                if (cnt == '0) begin
                    state_nxt = S_NOV2;
                    cnt_nxt   = NOV_LAST;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_NOV2: begin
                // Run request is only honoured here, so frames always complete.
                if (cnt == '0) begin
                    state_nxt = en_i ? S_PH1 : S_IDLE;
                    cnt_nxt   = en_i ? h_last : '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            phi1_o      <= 1'b0;
            phi2_o      <= 1'b0;
            phi1b_o     <= 1'b1;
            phi2b_o     <= 1'b1;
            busy_o      <= 1'b0;
            csync_meta  <= 1'b0;
            csync       <= 1'b0;
            primed      <= 1'b0;
            pol_o       <= 1'b0;
            event_o     <= 1'b0;
            polxevent_o <= 1'b0;
            event_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            phi1_o      <= (state_nxt == S_PH1);
            phi2_o      <= (state_nxt == S_PH2);
            phi1b_o     <= (state_nxt != S_PH1);
            phi2b_o     <= (state_nxt != S_PH2);
            busy_o      <= (state_nxt != S_IDLE);
            csync_meta  <= compout_i;
            csync       <= csync_meta;
            if (sample) begin
                primed <= 1'b1;
                pol_o  <= csync;
            end else if (state == S_IDLE) begin
                primed <= 1'b0;
            end
            event_o     <= evt_nxt;
            polxevent_o <= evt_nxt && csync;
            // A clear landing on an event pulse keeps that event in the count.
            if (clr_i) begin
                event_cnt_o <= event_o ? EVT_CNT_W'(1) : '0;
            end else if (event_o && (event_cnt_o != {EVT_CNT_W{1'b1}})) begin
                event_cnt_o <= event_cnt_o + EVT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sc_filter_phase_ctrl.sv
// Randomized frame-level bench for sc_filter_phase_ctrl with an expected-frame queue
// and a negedge monitor that measures phase run lengths and sample results.
module tb_sc_filter_phase_ctrl;

    localparam int DIV_W = 8;
    localparam int NOV   = 2;
    localparam int EW    = 2;
    localparam int REC_W = 22;

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             en_i;
    logic [DIV_W-1:0] half_period_i;
    logic             clr_i;
    logic             compout_i;
    logic             phi1_o, phi2_o, phi1b_o, phi2b_o;
    logic             pol_o, event_o, polxevent_o, busy_o;
    logic [EW-1:0]    event_cnt_o;

    sc_filter_phase_ctrl #(
        .DIV_W(DIV_W), .NOV_CYC(NOV), .EVT_CNT_W(EW)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en_i(en_i),
        .half_period_i(half_period_i), .clr_i(clr_i), .compout_i(compout_i),
        .phi1_o(phi1_o), .phi2_o(phi2_o), .phi1b_o(phi1b_o), .phi2b_o(phi2b_o),
        .pol_o(pol_o), .event_o(event_o), .polxevent_o(polxevent_o),
        .event_cnt_o(event_cnt_o), .busy_o(busy_o)
    );

    // clock / reset
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    // record layout: {h1[7:0], h2[7:0], pol, evt, polx, cont, cnt[1:0]}
    logic [REC_W-1:0] exp_q[$];

    // reference model state (frame level)
    logic pol_m;
    logic primed_m;
    int   cnt_m;
    logic clr_next_m;
    logic dir_seq [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    // monitor
    int               mph, run1, gap, run2, post;
    logic             mon_chk, mon_cnt_pend;
    logic [EW-1:0]    mon_exp_cnt;
    logic [REC_W-1:0] rec;
    logic             inv_ok;

    initial begin
        mph = 0; run1 = 0; gap = 0; run2 = 0; post = 0;
        mon_cnt_pend = 1'b0; mon_exp_cnt = '0; rec = '0;
    end

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            mph = 0; run1 = 0; gap = 0; run2 = 0; post = 0;
            mon_cnt_pend = 1'b0;
        end else begin
            mon_chk = 1'b0;
            if (mon_cnt_pend) begin
                check("event_cnt", int'(event_cnt_o), int'(mon_exp_cnt));
                mon_cnt_pend = 1'b0;
            end
            case (mph)
                0: if (phi1_o) begin mph = 1; run1 = 1; end
                1: if (phi1_o) run1++; else begin mph = 2; gap = 1; end
                2: if (phi2_o) begin mph = 3; run2 = 1; end else gap++;
                3: begin
                    if (phi2_o) run2++;
                    else if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        mph = 0;
                    end else begin
                        rec = exp_q.pop_front();
                        check("phi1_high_len", run1, int'(rec[21:14]));
                        check("nov1_len", gap, NOV);
                        check("phi2_high_len", run2, int'(rec[13:6]));
                        mph = 4;
                        post = 1;
                    end
                end
                default: begin
                    post++;
                    if (post == NOV) check("busy_in_nov2", int'(busy_o), 1);
                    if (post == NOV + 1) begin
                        mon_chk = 1'b1;
                        check("pol", int'(pol_o), int'(rec[5]));
                        check("event", int'(event_o), int'(rec[4]));
                        check("polxevent", int'(polxevent_o), int'(rec[3]));
                        mon_cnt_pend = 1'b1;
                        mon_exp_cnt  = rec[1:0];
                        if (rec[2]) begin
                            check("next_phi1_start", int'(phi1_o), 1);
                            mph = 1;
                            run1 = 1;
                        end else begin
                            check("idle_busy", int'(busy_o), 0);
                            check("idle_phi1", int'(phi1_o), 0);
                            mph = 0;
                        end
                    end
                end
            endcase
            inv_ok = !(phi1_o && phi2_o) && (phi1b_o == !phi1_o) && (phi2b_o == !phi2_o)
                     && (mon_chk || (!event_o && !polxevent_o));
            check("cycle_invariant", int'(inv_ok), 1);
        end
    end

    // driver tasks
    task automatic wait_phi1_rise(output bit ok);
        logic p;
        p  = phi1_o;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge wb_clk_i);
            if (phi1_o && !p) begin
                ok = 1'b1;
                break;
            end
            p = phi1_o;
        end
        if (!ok) check("phi1_rise_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o || mon_cnt_pend) && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        @(negedge wb_clk_i);
    endtask

    // h_mode < 0 picks random half periods; directed uses dir_seq for compout.
    task automatic run_session(input int nframes, input int h_mode, input bit directed, input bit allow_clr);
        int   h_cur, h_new;
        logic c, evt, last;
        bit   ok;
        primed_m   = 1'b0;
        clr_next_m = 1'b0;
        h_cur = (h_mode < 0) ? int'($urandom_range(0, 4)) : h_mode;
        half_period_i = DIV_W'(h_cur);
        @(negedge wb_clk_i);
        en_i = 1'b1;
        for (int f = 0; f < nframes; f++) begin
            wait_phi1_rise(ok);
            if (!ok) begin
                en_i = 1'b0;
                return;
            end
            clr_i = clr_next_m;
            h_new = (h_mode < 0) ? int'($urandom_range(0, 4)) : h_mode;
            half_period_i = DIV_W'(h_new);
            c = directed ? dir_seq[f % 5] : logic'($urandom_range(0, 1));
            compout_i = c;
            evt = primed_m && (c != pol_m);
            pol_m = c;
            primed_m = 1'b1;
            last = (f == nframes - 1);
            clr_next_m = (!last && allow_clr) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (clr_next_m) cnt_m = evt ? 1 : 0;
            else if (evt && cnt_m < 3) cnt_m++;
            exp_q.push_back({8'(eff(h_cur)), 8'(eff(h_new)), c, evt, c & evt, !last, 2'(cnt_m)});
            h_cur = h_new;
            @(negedge wb_clk_i);
            clr_i = 1'b0;
            if (last) en_i = 1'b0;
        end
        drain();
    endtask

    initial begin
        int n;
        dir_seq[0] = 1'b0; dir_seq[1] = 1'b1; dir_seq[2] = 1'b1;
        dir_seq[3] = 1'b0; dir_seq[4] = 1'b1;
        wb_rst_i = 1'b1; en_i = 1'b0; half_period_i = '0;
        clr_i = 1'b0; compout_i = 1'b0;
        pol_m = 1'b0; primed_m = 1'b0; cnt_m = 0; clr_next_m = 1'b0;
        #2;
        check("rst_phi1", int'(phi1_o), 0);
        check("rst_phi2", int'(phi2_o), 0);
        check("rst_phi1b", int'(phi1b_o), 1);
        check("rst_phi2b", int'(phi2b_o), 1);
        check("rst_pol", int'(pol_o), 0);
        check("rst_event", int'(event_o), 0);
        check("rst_polx", int'(polxevent_o), 0);
        check("rst_cnt", int'(event_cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;

        run_session(6, 3, 1'b0, 1'b1);
        run_session(6, 0, 1'b0, 1'b1);
        run_session(25, -1, 1'b0, 1'b1);
        run_session(5, 3, 1'b1, 1'b0);
        check("directed_cnt_saturated", int'(event_cnt_o), 3);

        // asynchronous reset landing mid-PH2, away from any clock edge
        half_period_i = DIV_W'(3);
        @(negedge wb_clk_i);
        en_i = 1'b1;
        n = 0;
        while (!phi2_o && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 100) check("phi2_wait_timeout", 0, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_rst_phi2", int'(phi2_o), 0);
        check("async_rst_phi2b", int'(phi2b_o), 1);
        check("async_rst_cnt", int'(event_cnt_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_pol", int'(pol_o), 0);
        en_i = 1'b0;
        pol_m = 1'b0;
        cnt_m = 0;
        exp_q.delete();
        repeat (2) @(negedge wb_clk_i);
        #3 wb_rst_i = 1'b0;
        run_session(6, -1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
